// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single main-memory port between the I-cache (instruction fill,
// read-only) and the D-cache (load fill / store write-through). A grant is held
// for a whole BURST-beat transaction, and mem_ready is steered only to the
// current owner. The I-side has priority. A streak counter makes sure the
// D-side is eventually served even when the I-side keeps requesting.
//
// Parameters
//   BURST         beats (mem_ready pulses) per transaction, >= 1
//   MAX_I_STREAK  consecutive I wins allowed while D waits, >= 1
//
// Ports
//   clk          in   1   clock, all state changes on posedge
//   clr          in   1   asynchronous active-high reset
//   i_strobe     in   1   I-cache request, held until its last i_ready
//   i_a          in   32  I-cache word address
//   i_ready      out  1   mem_ready routed to the I-cache
//   d_strobe     in   1   D-cache request, held until its last d_ready
//   d_rw         in   1   D request is a write (1) or a read (0)
//   d_a          in   32  D-cache word address
//   d_din        in   32  D-cache store data
//   d_ready      out  1   mem_ready routed to the D-cache
//   mem_a        out  32  address to memory
//   mem_access   out  1   memory request strobe
//   mem_write    out  1   memory write enable
//   mem_st_data  out  32  store data to memory
//   mem_ready    in   1   memory beat-complete pulse
//   sel_i        out  1   I-cache owns the port
//   busy         out  1   any grant state
//
// State      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no owner, arbitrate on this cycle's strobes, no memory traffic
// S_GNT_I    | I-cache owns the port until its last beat or strobe drop
// S_GNT_D    | D-cache owns the port until its last beat or strobe drop
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int BURST        = 1,
  parameter int MAX_I_STREAK = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        i_strobe,
  input  logic [31:0] i_a,
  output logic        i_ready,
  input  logic        d_strobe,
  input  logic        d_rw,
  input  logic [31:0] d_a,
  input  logic [31:0] d_din,
  output logic        d_ready,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  output logic        sel_i,
  output logic        busy
);

  localparam int BEAT_W   = (BURST > 1) ? $clog2(BURST + 1) : 1;
  localparam int STREAK_W = (MAX_I_STREAK > 1) ? $clog2(MAX_I_STREAK + 1) : 1;

  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_I_STREAK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_e;

  state_e              state_q,  state_d;
  logic [BEAT_W-1:0]   beat_q,   beat_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic d_starved;

  // D has waited through the allowed number of I transactions.
  assign d_starved = d_strobe && (streak_q == STREAK_MAX);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    streak_d = streak_q;

    unique case (state_q)
      S_IDLE: begin
        beat_d = '0;
        if (i_strobe && !d_starved) begin
          state_d = S_GNT_I;
        end else if (d_strobe) begin
          state_d  = S_GNT_D;
          streak_d = '0;
        end
      end

      S_GNT_I: begin
        // A dropped strobe wins over a coincident mem_ready: the owner has
        // walked away, so the transaction is abandoned and the streak kept.
        if (!i_strobe) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else if (mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
            beat_d  = '0;
            if (!d_strobe) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      S_GNT_D: begin
        if (!d_strobe) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else if (mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Port steering is combinational from the registered owner so that a strobe
  // drop removes mem_access in the same cycle.
  always_comb begin
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    mem_a       = '0;
    mem_access  = 1'b0;
    mem_write   = 1'b0;
    mem_st_data = '0;
    sel_i       = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      S_GNT_I: begin
        mem_a      = i_a;
        mem_access = i_strobe;
        i_ready    = mem_ready;
        sel_i      = 1'b1;
        busy       = 1'b1;
      end

      S_GNT_D: begin
        mem_a       = d_a;
        mem_access  = d_strobe;
        mem_write   = d_rw && d_strobe;
        mem_st_data = d_din;
        d_ready     = mem_ready;
        busy        = 1'b1;
      end

      default: begin
      end
    endcase
  end

endmodule
